// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame width and the system baud divisor.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS         = 8;
    localparam int unsigned UART_CLKS_PER_BIT_9600 = 1250;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO with wrap-bit pointers and overrun detection.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic [UART_DATA_BITS-1:0]     data_i,
    input  logic                          pop_i,
    output logic [UART_DATA_BITS-1:0]     data_o,
    output logic                          valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overrun_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]               wr_ptr_q, wr_ptr_d;
    logic [AW:0]               rd_ptr_q, rd_ptr_d;
    logic                      full, empty, do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign do_pop    = pop_i && !empty;
    assign do_push   = push_i && (!full || do_pop);
    assign overrun_o = push_i && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Storage is cleared on reset so the head byte reads 0 while empty after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o = !empty;
    assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling FSM, FWFT receive FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_9600,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          i_CLK,
    input  logic                          i_RST,
    input  logic                          i_RXD,
    output logic [UART_DATA_BITS-1:0]     o_DATA,
    output logic                          o_VALID,
    input  logic                          i_READY,
    output logic                          o_BUSY,
    output logic                          o_FRAME_ERR,
    output logic                          o_OVERRUN,
    output logic [$clog2(FIFO_DEPTH):0]   o_COUNT
);

    localparam int unsigned    CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic                       sync1_q, rxd_s;
    rx_state_e                  state_q, state_d;
    logic [CW-1:0]              clk_cnt_q, clk_cnt_d;
    logic [2:0]                 bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic                       push, frame_err;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            sync1_q   <= 1'b1;
            rxd_s     <= 1'b1;
            state_q   <= RX_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            sync1_q   <= i_RXD;
            rxd_s     <= sync1_q;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rxd_s) begin
                    state_d   = RX_START;
                    clk_cnt_d = '0;
                end
            end
            RX_START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rxd_s ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rxd_s;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                // Pushing at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    if (rxd_s) begin
                        push    = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = RX_WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_WAIT_IDLE: begin
                if (rxd_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign o_BUSY      = (state_q != RX_IDLE);
    assign o_FRAME_ERR = frame_err;

    uart_rx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (i_CLK),
        .rst_i     (i_RST),
        .push_i    (push),
        .data_i    (shift_d),
        .pop_i     (i_READY),
        .data_o    (o_DATA),
        .valid_o   (o_VALID),
        .count_o   (o_COUNT),
        .overrun_o (o_OVERRUN)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a byte-queue model.
module tb_uart_rx;

    localparam int unsigned CPB    = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PUSH_C = 3 + CPB / 2 + 9 * CPB;

    localparam int unsigned M_NORM  = 0;
    localparam int unsigned M_RAND  = 1;
    localparam int unsigned M_PULSE = 2;
    localparam int unsigned M_ABORT = 3;
    localparam int unsigned M_LAT   = 4;

    logic                      clk = 1'b0;
    logic                      rst, rxd, ready;
    logic [7:0]                o_data;
    logic                      o_valid, o_busy, o_ferr, o_ovr;
    logic [$clog2(DEPTH):0]    o_count;

    int unsigned n_cmp = 0, n_bad = 0;
    int unsigned fe_seen = 0, ov_seen = 0, exp_fe = 0, exp_ov = 0;
    int unsigned max_cnt = 0, n_pop = 0;
    logic [7:0]  exp_q[$];
    logic        mon_exp_valid;

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_RXD       (rxd),
        .o_DATA      (o_data),
        .o_VALID     (o_valid),
        .i_READY     (ready),
        .o_BUSY      (o_busy),
        .o_FRAME_ERR (o_ferr),
        .o_OVERRUN   (o_ovr),
        .o_COUNT     (o_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ov++;
    endfunction

    // Model-driven monitor: occupancy, head byte on every pop, and error pulses.
    always @(negedge clk) begin
        if (!rst) begin
            mon_exp_valid = (exp_q.size() != 0);
            check_eq("valid", {31'd0, o_valid}, {31'd0, mon_exp_valid});
            check_eq("count", 32'(o_count), exp_q.size());
            if (32'(o_count) > max_cnt) max_cnt = 32'(o_count);
            if (o_ferr) fe_seen++;
            if (o_ovr)  ov_seen++;
            if (o_ferr || o_ovr) check_eq("pulse_excl", {31'd0, o_ferr & o_ovr}, 32'd0);
            if (mon_exp_valid && ready) begin
                n_pop++;
                check_eq("pop_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk); #1;
            rxd = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned mode);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int unsigned c = 0; c < 10 * CPB; c++) begin
            @(posedge clk); #1;
            if (mode == M_ABORT && c == 5 * CPB + CPB / 2 + 1) begin
                rst = 1'b0;
                rxd = 1'b1;
                exp_q.delete();
                return;
            end
            rxd = fr[c / CPB];
            if (mode == M_RAND)  ready = 1'($urandom_range(0, 1));
            if (mode == M_PULSE) ready = (c == PUSH_C - 1);
            if (mode == M_ABORT && c == 5 * CPB + CPB / 2) rst = 1'b1;
            if (mode == M_LAT) begin
                if (c == CPB)        check_eq("busy_in_frame", {31'd0, o_busy}, 32'd1);
                if (c == PUSH_C - 1) check_eq("lat_pre", {31'd0, o_valid}, 32'd0);
                if (c == PUSH_C)     check_eq("lat_post", {31'd0, o_valid}, 32'd1);
            end
            if (c == PUSH_C && stop) model_push(b);
        end
        if (!stop) exp_fe++;
        if (mode == M_RAND || mode == M_PULSE) ready = 1'b0;
    endtask

    task automatic drain();
        ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        ready = 1'b0;
        check_eq("drain_done", exp_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        logic       rstop;
        int unsigned pop0;

        rst = 1'b1; rxd = 1'b1; ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
        check_eq("rst_count", 32'(o_count), 32'd0);
        check_eq("rst_data",  {24'd0, o_data}, 32'd0);
        check_eq("rst_busy",  {31'd0, o_busy}, 32'd0);
        check_eq("rst_ferr",  {31'd0, o_ferr}, 32'd0);
        check_eq("rst_ovr",   {31'd0, o_ovr},  32'd0);
        rst = 1'b0;
        idle(4);

        // Single byte with latency check
        send_frame(8'h61, 1'b1, M_LAT);
        idle(CPB);
        check_eq("t1_data",  {24'd0, o_data}, 32'h61);
        check_eq("t1_count", 32'(o_count), 32'd1);
        check_eq("t1_fe",    fe_seen, 32'd0);
        check_eq("t1_ov",    ov_seen, 32'd0);
        drain();

        // Back-to-back frames with consumer always ready
        max_cnt = 0;
        pop0 = n_pop;
        ready = 1'b1;
        send_frame(8'h00, 1'b1, M_NORM);
        send_frame(8'hFF, 1'b1, M_NORM);
        send_frame(8'hA5, 1'b1, M_NORM);
        send_frame(8'h5A, 1'b1, M_NORM);
        idle(CPB);
        ready = 1'b0;
        check_eq("t2_pops",    n_pop - pop0, 32'd4);
        check_eq("t2_max_cnt", max_cnt, 32'd1);

        // Glitch shorter than half a bit
        for (int unsigned c = 0; c < CPB; c++) begin
            @(posedge clk); #1;
            rxd = (c < CPB / 4) ? 1'b0 : 1'b1;
            if (c == CPB / 2) check_eq("t3_busy_mid", {31'd0, o_busy}, 32'd1);
        end
        idle(CPB);
        check_eq("t3_busy_end", {31'd0, o_busy}, 32'd0);
        check_eq("t3_fe", fe_seen, exp_fe);

        // Framing error followed by a break, then a good byte
        send_frame(8'h3C, 1'b0, M_NORM);
        for (int unsigned c = 0; c < 3 * CPB; c++) begin
            @(posedge clk); #1;
            rxd = 1'b0;
        end
        idle(2 * CPB);
        send_frame(8'h12, 1'b1, M_NORM);
        idle(CPB);
        check_eq("t4_fe",    fe_seen, exp_fe);
        check_eq("t4_fe1",   fe_seen, 32'd1);
        check_eq("t4_data",  {24'd0, o_data}, 32'h12);
        check_eq("t4_count", 32'(o_count), 32'd1);
        drain();

        // Overrun on the fifth byte, then the same with a pop on the push cycle
        for (int unsigned i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, M_NORM);
        idle(CPB);
        check_eq("t5_count", 32'(o_count), 32'd4);
        check_eq("t5_ov",    ov_seen, exp_ov);
        check_eq("t5_ov1",   ov_seen, 32'd1);
        drain();
        for (int unsigned i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, M_NORM);
        send_frame(8'h05, 1'b1, M_PULSE);
        idle(CPB);
        check_eq("t5b_count", 32'(o_count), 32'd4);
        check_eq("t5b_ov",    ov_seen, 32'd1);
        check_eq("t5b_head",  {24'd0, o_data}, 32'h02);
        drain();

        // Reset during data bit 4 with a byte already buffered
        send_frame(8'h42, 1'b1, M_NORM);
        send_frame(8'h61, 1'b1, M_ABORT);
        check_eq("t6_valid", {31'd0, o_valid}, 32'd0);
        check_eq("t6_count", 32'(o_count), 32'd0);
        check_eq("t6_data",  {24'd0, o_data}, 32'd0);
        check_eq("t6_busy",  {31'd0, o_busy}, 32'd0);
        idle(2 * CPB);
        check_eq("t6_busy_idle", {31'd0, o_busy}, 32'd0);
        send_frame(8'h61, 1'b1, M_NORM);
        idle(CPB);
        check_eq("t6_data2", {24'd0, o_data}, 32'h61);
        drain();

        // Random bytes, stop bits, gaps and consumer readiness
        for (int unsigned k = 0; k < 12; k++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
            send_frame(rb, rstop, M_RAND);
            if (!rstop) idle(CPB);
            idle($urandom_range(0, CPB));
        end
        idle(CPB);
        check_eq("rnd_fe", fe_seen, exp_fe);
        check_eq("rnd_ov", ov_seen, exp_ov);
        drain();
        idle(4);
        check_eq("final_busy", {31'd0, o_busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver inside `system`. It takes the external 8N1 line on `i_UART_TXD` and delivers bytes over a valid/ready interface to the bus-side UART register block. It contains:
- a 2-flop synchronizer
- a mid-bit sampling receive FSM
- a small first-word-fall-through byte FIFO

Line idles high. Frame is LSB-first: 1 start bit (0), 8 data bits, 1 stop bit (1).

Parameters:
- CLKS_PER_BIT, 1250, i_CLK cycles per bit period (9600 baud at the system clock); must be >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- i_CLK  in  1  system clock, all logic on rising edge.
- i_RST  in  1  reset, synchronous, active-high.
- i_RXD  in  1  asynchronous serial input (tied to i_UART_TXD at system level).
- o_DATA  out  8  FIFO head byte; valid only while o_VALID=1.
- o_VALID  out  1  FIFO not empty.
- i_READY  in  1  consumer pop; a pop occurs when o_VALID && i_READY.
- o_BUSY  out  1  FSM not in IDLE.
- o_FRAME_ERR  out  1  one-cycle pulse: stop bit sampled 0.
- o_OVERRUN  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- o_COUNT  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values:
  - Synchronizer flops = 1; FSM = IDLE; bit/clock counters = 0; shift register = 0.
  - FIFO empty: rd/wr pointers = 0, o_COUNT = 0, o_VALID = 0, o_DATA = 0.
  - o_BUSY, o_FRAME_ERR, o_OVERRUN = 0.
- Reset mid-frame aborts the frame; the partial byte is never written.
- Synchronizer: rxd_s = 2nd flop of i_RXD. Input-to-FSM latency is 2 cycles. The FSM sees only rxd_s.
- FSM states IDLE, START, DATA, STOP, WAIT_IDLE; clk_cnt is a 0..CLKS_PER_BIT-1 counter.
  - IDLE: on rxd_s=0, go to START with clk_cnt=0.
  - START: when clk_cnt = CLKS_PER_BIT/2-1, sample rxd_s.
    - 0: go to DATA, clk_cnt=0, bit_idx=0.
    - 1: glitch; return to IDLE with no outputs.
  - DATA: when clk_cnt = CLKS_PER_BIT-1, shift rxd_s into bit[bit_idx] (LSB first) and reset clk_cnt.
    - After bit_idx=7 is sampled, go to STOP.
  - STOP: when clk_cnt = CLKS_PER_BIT-1, sample rxd_s.
    - 1: go to IDLE and push the byte into the FIFO the same cycle. This is half a bit early, which allows back-to-back frames.
    - 0: pulse o_FRAME_ERR, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxd_s=1, then go to IDLE. A break condition therefore yields exactly one frame error.
- All samples are taken at the nominal mid-bit point. No majority vote.
- Latency: the push occurs 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the falling start edge on i_RXD (±1 cycle sync uncertainty). o_VALID rises the cycle after the push.
- FIFO behaviour:
  - Memory is registered; read is first-word-fall-through, so o_DATA = mem[rd_ptr].
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
    - Full = (pointer MSBs differ) && (low bits equal).
    - Empty = pointers equal.
  - Push while not full: write, wr_ptr+1.
  - Push while full with a pop in the same cycle: both happen; occupancy unchanged; no overrun.
  - Push while full with no pop: byte dropped; o_OVERRUN pulses that cycle; FIFO contents untouched.
  - Pop while empty: ignored (o_VALID=0).
  - Push and pop on an empty FIFO in the same cycle: the pop is ignored and the byte is stored.
  - o_COUNT is always wr_ptr − rd_ptr.
- o_FRAME_ERR and o_OVERRUN are never asserted in the same cycle and are never asserted for more than one cycle per frame.

Decomposition:
- Shared package (uart_pkg): FSM state encoding constants (RX_IDLE … RX_WAIT_IDLE) and the UART_DATA_BITS=8 constant.
- CLKS_PER_BIT for 9600 baud is a system-level constant in the same package so the TX block and the bench reuse it.
- One sub-module: uart_rx_fifo (parameter FIFO_DEPTH, width 8) holding the pointers, full/empty/count and overrun detection. The FSM and synchronizer stay in uart_rx.

Test Plan:
1. Single byte: send 0x61 at CLKS_PER_BIT=1250 with i_READY=0 → o_VALID rises about 11877 cycles after the start edge; o_DATA=0x61; o_COUNT=1; no error pulses.
2. Back-to-back: 0x00, 0xFF, 0xA5, 0x5A with no idle gap and i_READY=1 → four pops in order, values exact, o_COUNT never exceeds 1.
3. Glitch rejection: drive i_RXD low for CLKS_PER_BIT/4 cycles then high → FSM returns to IDLE, no push, no error pulse.
4. Framing error: send 0x3C with stop bit 0, then hold the line low for 3 bit times, then idle, then send 0x12 → exactly one o_FRAME_ERR pulse, 0x3C not stored, 0x12 received correctly.
5. Overrun: i_READY=0, send 5 bytes 0x01..0x05 with FIFO_DEPTH=4 → o_COUNT=4; o_OVERRUN pulses once at the 5th stop sample; draining yields 0x01..0x04. Repeat with i_READY asserted on the 5th push cycle → no overrun; 0x05 is stored.
6. Reset mid-frame: assert i_RST for 1 cycle during DATA bit 4 of 0x61 → all outputs return to reset values, FIFO empty; a following clean 0x61 frame is received correctly.
